// File: rtl/residue_check_arbiter.sv
// -----------------------------------------------------------------------------
// residue_check_arbiter
//
// Purpose: shares one pipelined mod-31 residue checker between the two
// simple-ALU issue lanes. Each lane writes {result, predicted residue, tag}
// into a 2-entry skid FIFO. A round-robin arbiter pops one entry per cycle
// into an issue register. The entry then goes through a fold stage and a
// reduce/compare stage. The block reports a per-tag mismatch and keeps a
// saturating error count plus a sticky flag for the recovery logic.
//
// Ports:
//   clk                    clock, all state on the rising edge
//   reset                  asynchronous, active-low, clears all state
//   laneN_valid_i          lane N offers an entry
//   laneN_ready_o          lane N buffer can accept (registered state only)
//   laneN_result_i         ALU result (SIZE_DATA bits)
//   laneN_res_i            predicted residue (SIZE_MOD bits)
//   laneN_tag_i            active-list tag (TAG_W bits)
//   flush_i                kill all buffered and in-flight entries
//   clear_i                clear the error counter and the sticky flag
//   chk_valid_o            check result valid this cycle
//   chk_lane_o             lane of the reported entry (0 when not valid)
//   chk_tag_o              tag of the reported entry (0 when not valid)
//   chk_mismatch_o         computed residue differs from prediction
//   err_cnt_o              saturating mismatch count
//   err_sticky_o           set on any mismatch until clear_i
//
// Latency: an entry pushed at edge N into an idle lane is popped into the
// issue register at edge N+1, folded at N+2 and reported after edge N+3.
// -----------------------------------------------------------------------------
module residue_check_arbiter #(
  parameter int SIZE_DATA = 32,
  parameter int SIZE_MOD  = 5,
  parameter int TAG_W     = 7,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 lane0_valid_i,
  output logic                 lane0_ready_o,
  input  logic [SIZE_DATA-1:0] lane0_result_i,
  input  logic [SIZE_MOD-1:0]  lane0_res_i,
  input  logic [TAG_W-1:0]     lane0_tag_i,
  input  logic                 lane1_valid_i,
  output logic                 lane1_ready_o,
  input  logic [SIZE_DATA-1:0] lane1_result_i,
  input  logic [SIZE_MOD-1:0]  lane1_res_i,
  input  logic [TAG_W-1:0]     lane1_tag_i,
  input  logic                 flush_i,
  input  logic                 clear_i,
  output logic                 chk_valid_o,
  output logic                 chk_lane_o,
  output logic [TAG_W-1:0]     chk_tag_o,
  output logic                 chk_mismatch_o,
  output logic [CNT_W-1:0]     err_cnt_o,
  output logic                 err_sticky_o
);

  localparam int ENT_W = SIZE_DATA + SIZE_MOD + TAG_W;

  genvar gi;

  // ---------------------------------------------------------------------------
  // Lane FIFOs
  // ---------------------------------------------------------------------------
  logic [1:0]            w_in_valid;
  logic [1:0][ENT_W-1:0] w_in_ent;
  logic [1:0][ENT_W-1:0] w_head;
  logic [1:0]            w_nonempty;
  logic [1:0]            w_ready;
  logic [1:0]            w_grant;

  // Holds ready low until the first edge after reset is released.
  logic r_ready_en;

  assign w_in_valid  = {lane1_valid_i, lane0_valid_i};
  assign w_in_ent[0] = {lane0_result_i, lane0_res_i, lane0_tag_i};
  assign w_in_ent[1] = {lane1_result_i, lane1_res_i, lane1_tag_i};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
    end
  end

  for (gi = 0; gi < 2; gi++) begin : g_lane
    logic [ENT_W-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             w_push;
    logic             w_pop;

    // Ready comes only from registered occupancy, so a full buffer blocks a
    // push even when the same lane is being popped this cycle.
    assign w_ready[gi]    = r_ready_en & (r_count != 2'd2);
    assign w_nonempty[gi] = (r_count != 2'd0);
    assign w_head[gi]     = r_mem[r_rd_ptr];
    assign w_push         = w_in_valid[gi] & w_ready[gi] & ~flush_i;
    assign w_pop          = w_grant[gi] & ~flush_i;

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_mem[0] <= '0;
        r_mem[1] <= '0;
        r_wr_ptr <= 1'b0;
        r_rd_ptr <= 1'b0;
        r_count  <= 2'd0;
      end else if (flush_i) begin
        r_wr_ptr <= 1'b0;
        r_rd_ptr <= 1'b0;
        r_count  <= 2'd0;
      end else begin
        if (w_push) begin
          r_mem[r_wr_ptr] <= w_in_ent[gi];
          r_wr_ptr        <= ~r_wr_ptr;
        end
        if (w_pop) begin
          r_rd_ptr <= ~r_rd_ptr;
        end
        r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
    end
  end

  assign lane0_ready_o = w_ready[0];
  assign lane1_ready_o = w_ready[1];

  // ---------------------------------------------------------------------------
  // Round-robin arbiter and issue register
  // ---------------------------------------------------------------------------
  // r_last_grant holds the lane granted most recently. On a tie the other
  // lane wins. Its reset value is 1, so lane 0 wins the first tie.
  logic             r_last_grant;
  logic             r_iss_valid;
  logic             r_iss_lane;
  logic [ENT_W-1:0] r_iss_ent;

  assign w_grant[0] = w_nonempty[0] & (~w_nonempty[1] | r_last_grant);
  assign w_grant[1] = w_nonempty[1] & (~w_nonempty[0] | ~r_last_grant);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_grant <= 1'b1;
      r_iss_valid  <= 1'b0;
      r_iss_lane   <= 1'b0;
      r_iss_ent    <= '0;
    end else if (flush_i) begin
      r_iss_valid <= 1'b0;
    end else begin
      r_iss_valid <= |w_grant;
      r_iss_lane  <= w_grant[1];
      r_iss_ent   <= w_grant[1] ? w_head[1] : w_head[0];
      if (|w_grant) begin
        r_last_grant <= w_grant[1];
      end
    end
  end

  logic [SIZE_DATA-1:0] w_iss_result;
  logic [SIZE_MOD-1:0]  w_iss_res;
  logic [TAG_W-1:0]     w_iss_tag;

  assign w_iss_result = r_iss_ent[ENT_W-1 -: SIZE_DATA];
  assign w_iss_res    = r_iss_ent[TAG_W +: SIZE_MOD];
  assign w_iss_tag    = r_iss_ent[TAG_W-1:0];

  // ---------------------------------------------------------------------------
  // Stage 1: fold. 32 = 1 (mod 31), so the 5-bit chunks can be summed directly.
  // The top 2 bits form a seventh chunk. Max sum is 6*31 + 3 = 189.
  // ---------------------------------------------------------------------------
  logic [7:0] w_chunk [6];
  logic [7:0] w_fold_sum;

  for (gi = 0; gi < 6; gi++) begin : g_chunk
    assign w_chunk[gi] = {3'b000, w_iss_result[gi*5 +: 5]};
  end

  always_comb begin
    w_fold_sum = {6'b000000, w_iss_result[31:30]};
    for (int i = 0; i < 6; i++) begin
      w_fold_sum = w_fold_sum + w_chunk[i];
    end
  end

  logic                r_s1_valid;
  logic                r_s1_lane;
  logic [TAG_W-1:0]    r_s1_tag;
  logic [SIZE_MOD-1:0] r_s1_res;
  logic [7:0]          r_s1_sum;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_valid <= 1'b0;
      r_s1_lane  <= 1'b0;
      r_s1_tag   <= '0;
      r_s1_res   <= '0;
      r_s1_sum   <= '0;
    end else if (flush_i) begin
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= r_iss_valid;
      r_s1_lane  <= r_iss_lane;
      r_s1_tag   <= w_iss_tag;
      r_s1_res   <= w_iss_res;
      r_s1_sum   <= w_fold_sum;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: reduce and compare. Folding the 8-bit sum once more gives a
  // value of at most 7 + 31 = 38. A single conditional subtract then lands
  // it in 0..30. A predicted residue of 31 is the same class as 0.
  // ---------------------------------------------------------------------------
  logic [5:0]          w_red_t;
  logic [5:0]          w_red;
  logic [SIZE_MOD-1:0] w_pred;
  logic                w_mismatch;

  assign w_red_t    = {3'b000, r_s1_sum[7:5]} + {1'b0, r_s1_sum[4:0]};
  assign w_red      = (w_red_t >= 6'd31) ? (w_red_t - 6'd31) : w_red_t;
  assign w_pred     = (r_s1_res == 5'h1F) ? 5'h00 : r_s1_res;
  assign w_mismatch = (w_red != {1'b0, w_pred});

  logic             r_chk_valid;
  logic             r_chk_lane;
  logic [TAG_W-1:0] r_chk_tag;
  logic             r_chk_mismatch;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_chk_valid    <= 1'b0;
      r_chk_lane     <= 1'b0;
      r_chk_tag      <= '0;
      r_chk_mismatch <= 1'b0;
    end else if (flush_i) begin
      r_chk_valid    <= 1'b0;
      r_chk_lane     <= 1'b0;
      r_chk_tag      <= '0;
      r_chk_mismatch <= 1'b0;
    end else begin
      r_chk_valid    <= r_s1_valid;
      r_chk_lane     <= r_s1_valid & r_s1_lane;
      r_chk_tag      <= r_s1_valid ? r_s1_tag : '0;
      r_chk_mismatch <= r_s1_valid & w_mismatch;
    end
  end

  // ---------------------------------------------------------------------------
  // Error counter: counts what is on the outputs this cycle. Flush does not
  // affect it. If clear and a mismatch arrive together, the mismatch is
  // counted after the clear.
  // ---------------------------------------------------------------------------
  logic             w_count_hit;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_err_sticky;

  assign w_count_hit = r_chk_valid & r_chk_mismatch;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_cnt    <= '0;
      r_err_sticky <= 1'b0;
    end else if (clear_i) begin
      r_err_cnt    <= w_count_hit ? {{(CNT_W-1){1'b0}}, 1'b1} : '0;
      r_err_sticky <= w_count_hit;
    end else if (w_count_hit) begin
      if (r_err_cnt != {CNT_W{1'b1}}) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end
      r_err_sticky <= 1'b1;
    end
  end

  assign chk_valid_o    = r_chk_valid;
  assign chk_lane_o     = r_chk_lane;
  assign chk_tag_o      = r_chk_tag;
  assign chk_mismatch_o = r_chk_mismatch;
  assign err_cnt_o      = r_err_cnt;
  assign err_sticky_o   = r_err_sticky;

endmodule
